sync_fifo_lvl: RTL and testbench
================================

# sync_fifo_lvl

Parametrised synchronous FIFO for the UART 16550 TX/RX data paths, succeeding the fixed-feature sync FIFO. It adds power-of-two depth selection, a fill-level output, and programmable almost-full/almost-empty thresholds. It also adds a 16550-style receive trigger flag and sticky overflow/underflow error flags. It sits between the register interface and the shift engines, one instance per direction.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, log2 of depth; depth = 2^ADDR_WIDTH (16 default, 2..8 legal)
- AFULL_LVL, 14, o_afull asserts when level >= AFULL_LVL
- AEMPTY_LVL, 2, o_aempty asserts when level <= AEMPTY_LVL

- i_sys_clk  in  1  single clock, all logic on rising edge
- i_sys_rst  in  1  synchronous, active-high reset
- i_fifo_rst  in  1  synchronous flush, same effect as reset on FIFO state
- i_wren  in  1  write request
- i_wdata  in  DATA_WIDTH  write data
- i_rden  in  1  read/pop request
- i_trig_sel  in  2  receive trigger level select: 0→1, 1→DEPTH/4, 2→DEPTH/2, 3→DEPTH-2 words
- o_rdata  out  DATA_WIDTH  read data
- o_rvalid  out  1  o_rdata holds a newly popped word (see Configuration)
- o_empty  out  1  level == 0
- o_full  out  1  level == DEPTH
- o_aempty  out  1  almost empty
- o_afull  out  1  almost full
- o_trig  out  1  level >= selected trigger level
- o_level  out  ADDR_WIDTH+1  current word count, 0..DEPTH
- o_ovf  out  1  sticky: write attempted while full
- o_udf  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr/rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH naturally. The level counter is separate, ADDR_WIDTH+1 bits wide.
- Write accepted iff i_wren && !o_full. Read accepted iff i_rden && !o_empty. Acceptance is decided on registered flags only.
- Write when full: dropped, memory and pointers are unchanged, and o_ovf is set. This holds even if a read is accepted in the same cycle.
- Read when empty: no pop and o_udf is set. This holds even if a write is accepted in the same cycle; that write still lands.
- Level update: +1 for write-only, -1 for read-only, unchanged when both are accepted.
- All flags are registered and derived from the next-state level, so they are valid in the same cycle as o_level.
- o_ovf and o_udf hold until i_sys_rst or i_fifo_rst.
- Reset/flush: pointers = 0, level = 0, o_empty = 1, o_aempty = 1, o_full = 0, o_afull = 0, o_trig = 0, o_ovf = 0, o_udf = 0, o_rvalid = 0, o_rdata = 0. Memory contents are not cleared.
- Reset or flush asserted in the same cycle as a write or read: reset wins and the access is discarded.
- i_trig_sel may change at any time; o_trig follows on the next edge.

## Timing
- Write at edge N: o_level, o_empty and the threshold flags update at edge N.
- Standard mode, read accepted at edge N: o_rdata is valid and o_rvalid = 1 for exactly the cycle after edge N. o_rdata holds its value otherwise.
- Back-to-back reads every cycle sustain one word per cycle.
- Write into an empty FIFO at edge N: a read is first accepted at edge N+1.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - o_rdata combinationally shows mem[rd_ptr] whenever !o_empty.
  - o_rvalid = !o_empty.
  - i_rden acknowledges and pops the word shown.
  - A write into an empty FIFO at edge N is visible on o_rdata after edge N.
- FIFO_FWFT_EN undefined: standard registered read with 1-cycle latency, as described under Timing.

## Structure
- Shared package fifo_pkg:
  - trigger-select encodings TRIG_1, TRIG_Q, TRIG_H, TRIG_F2
  - level-width helper constant
  - legal ADDR_WIDTH bounds
- Sub-module sync_fifo_ram: simple dual-port memory, DATA_WIDTH × 2^ADDR_WIDTH.
  - Synchronous write.
  - Read is registered or asynchronous according to FIFO_FWFT_EN.
- Pointer, level, flag and error logic stays in sync_fifo_lvl.

## Test plan
- Fill/drain, standard mode, depth 16: write 0x01..0x10.
  - Required: o_full = 1 after the 16th write and o_level = 16.
  - Read 16: o_rdata sequence is 0x01..0x10, each one cycle after its i_rden, and o_empty = 1 at the end.
- Thresholds: write 14 words, AFULL_LVL = 14.
  - Required: o_afull rises on the 14th write edge.
  - Read down to 2 words: o_aempty rises when o_level = 2.
  - i_trig_sel = 2 with 8 words: o_trig = 1; with 7 words: o_trig = 0.
- Overflow/underflow:
  - 17th write while full with simultaneous read: level becomes 15, 0x11 is not stored, and o_ovf = 1 stays set.
  - Read on empty: o_udf = 1, and it clears only after i_fifo_rst.
- Simultaneous read/write at level 5 for 20 cycles: level stays 5 and data order is preserved across pointer wrap.
- Flush mid-stream: assert i_fifo_rst with level 9 plus a concurrent write.
  - Required: the next cycle shows level 0, o_empty = 1, and the write discarded.
- FWFT build: write 0xA5 into an empty FIFO.
  - Required: o_rdata = 0xA5 with o_rvalid = 1 on the following cycle, without any i_rden.
  - A single i_rden then empties the FIFO.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the level-tracking sync FIFO: receive-trigger
// encodings, level-width helper and the legal address-width range.
package fifo_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'd0,
    TRIG_Q  = 2'd1,
    TRIG_H  = 2'd2,
    TRIG_F2 = 2'd3
  } trig_sel_e;

  localparam int unsigned ADDR_WIDTH_MIN = 2;
  localparam int unsigned ADDR_WIDTH_MAX = 8;

  // The level counter needs one bit more than the pointers to represent DEPTH.
  localparam int unsigned LVL_EXTRA_BITS = 1;

  function automatic int unsigned lvl_width(input int unsigned addr_width);
    return addr_width + LVL_EXTRA_BITS;
  endfunction

  function automatic int unsigned trig_words(input trig_sel_e sel, input int unsigned depth);
    case (sel)
      TRIG_1:  return 1;
      TRIG_Q:  return depth / 4;
      TRIG_H:  return depth / 2;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port FIFO storage: synchronous write, registered read by default,
// asynchronous read when FIFO_FWFT_EN is defined.
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = ^{srst_i, re_i};
  assign rdata_o   = mem_q[raddr_i];
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  // Only the output register is cleared; the array itself keeps its contents.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with fill level, almost-full/empty, receive trigger and
// sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_lvl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AFULL_LVL  = 14,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_fifo_rst,
  input  logic                  i_wren,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rden,
  input  logic [1:0]            i_trig_sel,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_aempty,
  output logic                  o_afull,
  output logic                  o_trig,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_ovf,
  output logic                  o_udf
);

  import fifo_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW    = lvl_width(ADDR_WIDTH);

  logic                  rst;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  aempty_q, aempty_d;
  logic                  afull_q, afull_d;
  logic                  trig_q, trig_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign rst = i_sys_rst || i_fifo_rst;

  // Acceptance looks only at registered flags, and a reset/flush kills the access.
  always_comb begin
    wr_acc   = i_wren && !full_q && !rst;
    rd_acc   = i_rden && !empty_q && !rst;
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    level_d = level_q;
    if (wr_acc && !rd_acc) begin
      level_d = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LW'(1);
    end

    empty_d  = (level_d == '0);
    full_d   = (32'(level_d) == DEPTH);
    aempty_d = (32'(level_d) <= AEMPTY_LVL);
    afull_d  = (32'(level_d) >= AFULL_LVL);
    trig_d   = (32'(level_d) >= trig_words(trig_sel_e'(i_trig_sel), DEPTH));
    ovf_d    = ovf_q || (i_wren && full_q);
    udf_d    = udf_q || (i_rden && empty_q);
  end

  always_ff @(posedge i_sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      trig_q   <= trig_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (i_sys_clk),
    .srst_i (rst),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(i_wdata),
    .re_i   (rd_acc),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign o_rdata  = empty_q ? '0 : ram_rdata;
  assign o_rvalid = !empty_q;
`else
  logic rvalid_q;

  always_ff @(posedge i_sys_clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
    end
  end

  assign o_rdata  = ram_rdata;
  assign o_rvalid = rvalid_q;
`endif

  assign o_empty  = empty_q;
  assign o_full   = full_q;
  assign o_aempty = aempty_q;
  assign o_afull  = afull_q;
  assign o_trig   = trig_q;
  assign o_level  = level_q;
  assign o_ovf    = ovf_q;
  assign o_udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl (depth 16); a FIFO_FWFT_EN build runs
// the fall-through sequence instead of the registered-read sequences.
module tb_sync_fifo_lvl;

  logic       clk = 1'b0;
  logic       i_sys_rst;
  logic       i_fifo_rst;
  logic       i_wren;
  logic [7:0] i_wdata;
  logic       i_rden;
  logic [1:0] i_trig_sel;
  logic [7:0] o_rdata;
  logic       o_rvalid;
  logic       o_empty;
  logic       o_full;
  logic       o_aempty;
  logic       o_afull;
  logic       o_trig;
  logic [4:0] o_level;
  logic       o_ovf;
  logic       o_udf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_lvl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AFULL_LVL (14),
    .AEMPTY_LVL(2)
  ) dut (
    .i_sys_clk (clk),
    .i_sys_rst (i_sys_rst),
    .i_fifo_rst(i_fifo_rst),
    .i_wren    (i_wren),
    .i_wdata   (i_wdata),
    .i_rden    (i_rden),
    .i_trig_sel(i_trig_sel),
    .o_rdata   (o_rdata),
    .o_rvalid  (o_rvalid),
    .o_empty   (o_empty),
    .o_full    (o_full),
    .o_aempty  (o_aempty),
    .o_afull   (o_afull),
    .o_trig    (o_trig),
    .o_level   (o_level),
    .o_ovf     (o_ovf),
    .o_udf     (o_udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_flags();
    return {o_empty, o_full, o_aempty, o_afull, o_trig, o_ovf, o_udf};
  endfunction

`ifndef FIFO_FWFT_EN
  typedef struct {
    bit         we;
    logic [7:0] wd;
    bit         re;
    logic [1:0] ts;
    bit         fr;
    int         exp_level;
    logic [6:0] exp_flags;  // {empty, full, aempty, afull, trig, ovf, udf}
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] mq[$];   // reference FIFO contents
  logic [7:0] sb[$];   // words popped, awaiting o_rvalid
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         exp_rv = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  function automatic int trig_lvl(input logic [1:0] ts);
    case (ts)
      2'd0:    return 1;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 14;
    endcase
  endfunction

  task automatic cycle(input bit we, input logic [7:0] wd, input bit re,
                       input logic [1:0] ts, input bit fr);
    bit         full_now;
    bit         empty_now;
    int         n;
    logic [6:0] ef;
    full_now   = (mq.size() == 16);
    empty_now  = (mq.size() == 0);
    i_wren     = we;
    i_wdata    = wd;
    i_rden     = re;
    i_trig_sel = ts;
    i_fifo_rst = fr;
    if (fr) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      exp_rv = 1'b0;
    end else begin
      if (we && full_now) m_ovf = 1'b1;
      if (re && empty_now) m_udf = 1'b1;
      exp_rv = re && !empty_now;
      if (exp_rv) sb.push_back(mq.pop_front());
      if (we && !full_now) mq.push_back(wd);
    end
    @(posedge clk);
    #1;
    i_wren     = 1'b0;
    i_rden     = 1'b0;
    i_fifo_rst = 1'b0;
    n  = mq.size();
    ef = {n == 0, n == 16, n <= 2, n >= 14, n >= trig_lvl(ts), m_ovf, m_udf};
    if (fr) m_rdata = 8'h00;
    if (o_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'(o_rvalid), 0);
      end else begin
        m_rdata = sb.pop_front();
      end
    end
    $display("txn we=%0d wd=%02h re=%0d ts=%0d fr=%0d -> lvl=%0d rv=%0d rd=%02h flags=%b",
             we, wd, re, ts, fr, o_level, o_rvalid, o_rdata, dut_flags());
    chk("level", 32'(o_level), 32'(n));
    chk("flags", 32'(dut_flags()), 32'(ef));
    chk("rvalid", 32'(o_rvalid), 32'(exp_rv));
    chk("rdata", 32'(o_rdata), 32'(m_rdata));
  endtask
`endif

  initial begin
    i_sys_rst  = 1'b1;
    i_fifo_rst = 1'b0;
    i_wren     = 1'b0;
    i_wdata    = 8'h00;
    i_rden     = 1'b0;
    i_trig_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(o_level), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_aempty", 32'(o_aempty), 1);
    chk("rst_afull", 32'(o_afull), 0);
    chk("rst_trig", 32'(o_trig), 0);
    chk("rst_ovf", 32'(o_ovf), 0);
    chk("rst_udf", 32'(o_udf), 0);
    chk("rst_rvalid", 32'(o_rvalid), 0);
    chk("rst_rdata", 32'(o_rdata), 0);
    i_sys_rst = 1'b0;

`ifdef FIFO_FWFT_EN
    i_wren  = 1'b1;
    i_wdata = 8'hA5;
    @(posedge clk);
    #1;
    i_wren = 1'b0;
    chk("fwft_rdata_now", 32'(o_rdata), 'hA5);
    chk("fwft_rvalid_now", 32'(o_rvalid), 1);
    chk("fwft_level", 32'(o_level), 1);
    @(posedge clk);
    #1;
    chk("fwft_rdata_next", 32'(o_rdata), 'hA5);
    chk("fwft_rvalid_next", 32'(o_rvalid), 1);
    i_rden = 1'b1;
    @(posedge clk);
    #1;
    i_rden = 1'b0;
    chk("fwft_pop_empty", 32'(o_empty), 1);
    chk("fwft_pop_rvalid", 32'(o_rvalid), 0);
    chk("fwft_pop_level", 32'(o_level), 0);
`else
    // Short directed table: underflow, flush, trigger select, simultaneous access.
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 0, 7'b1010001};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 0, 7'b1010000};
    vecs[2]  = '{1'b1, 8'hA1, 1'b0, 2'd0, 1'b0, 1, 7'b0010100};
    vecs[3]  = '{1'b1, 8'hA2, 1'b1, 2'd0, 1'b0, 1, 7'b0010100};
    vecs[4]  = '{1'b1, 8'hA3, 1'b0, 2'd0, 1'b0, 2, 7'b0010100};
    vecs[5]  = '{1'b1, 8'hA4, 1'b0, 2'd1, 1'b0, 3, 7'b0000000};
    vecs[6]  = '{1'b1, 8'hA5, 1'b0, 2'd1, 1'b0, 4, 7'b0000100};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 3, 7'b0000000};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 2, 7'b0010100};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1, 7'b0010100};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 0, 7'b1010000};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 0, 7'b1010001};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 0, 7'b1010000};
    for (int v = 0; v < 13; v++) begin
      cycle(vecs[v].we, vecs[v].wd, vecs[v].re, vecs[v].ts, vecs[v].fr);
      chk("vec_level", 32'(o_level), 32'(vecs[v].exp_level));
      chk("vec_flags", 32'(dut_flags()), 32'(vecs[v].exp_flags));
    end

    // Fill 0x01..0x10 with trigger at DEPTH/2, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 2'd2, 1'b0);
      if (i == 7)  chk("trig_h_7words", 32'(o_trig), 0);
      if (i == 8)  chk("trig_h_8words", 32'(o_trig), 1);
      if (i == 13) chk("afull_13", 32'(o_afull), 0);
      if (i == 14) chk("afull_14", 32'(o_afull), 1);
    end
    chk("fill_level", 32'(o_level), 16);
    chk("fill_full", 32'(o_full), 1);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
      chk("drain_data", 32'(o_rdata), 32'(i));
      chk("drain_rvalid", 32'(o_rvalid), 1);
      if (i == 13) chk("aempty_lvl3", 32'(o_aempty), 0);
      if (i == 14) chk("aempty_lvl2", 32'(o_aempty), 1);
    end
    chk("drain_empty", 32'(o_empty), 1);
    cycle(1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
    chk("rdata_hold", 32'(o_rdata), 'h10);

    // Overflow with a concurrent read: write dropped, level 15, flag sticky.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 8'h11, 1'b1, 2'd0, 1'b0);
    chk("ovf_level", 32'(o_level), 15);
    chk("ovf_set", 32'(o_ovf), 1);
    for (int i = 2; i <= 16; i++) cycle(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    chk("ovf_last_word", 32'(o_rdata), 'h10);
    chk("ovf_sticky", 32'(o_ovf), 1);
    chk("ovf_empty", 32'(o_empty), 1);

    // Underflow stays set until flushed.
    cycle(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    chk("udf_set", 32'(o_udf), 1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("udf_sticky", 32'(o_udf), 1);
    cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    chk("udf_flushed", 32'(o_udf), 0);
    chk("ovf_flushed", 32'(o_ovf), 0);

    // Level 5 with simultaneous read/write for 20 cycles across pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(8'h25 + i), 1'b1, 2'd0, 1'b0);
      chk("rw_level5", 32'(o_level), 5);
      chk("rw_data", 32'(o_rdata), 32'(8'h20 + i));
    end

    // Flush at level 9 with a concurrent write: write discarded.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 2'd0, 1'b0);
    chk("pre_flush_level", 32'(o_level), 9);
    cycle(1'b1, 8'hEE, 1'b0, 2'd0, 1'b1);
    chk("flush_level", 32'(o_level), 0);
    chk("flush_empty", 32'(o_empty), 1);
    cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("flush_write_dropped", 32'(o_level), 0);
    chk("scoreboard_drained", 32'(sb.size()), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
